// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern detector: FSM encoding and pattern width.
package seq_detect_pkg;

    localparam int unsigned PAT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/seq_match_core.sv
// Bit history, fill tracking and pattern compare; match is combinational on the
// bit being consumed so the parent can register it on the same edge.
module seq_match_core
    import seq_detect_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    output logic             match
);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [2:0]       fill_q, fill_d;

    always_comb begin
        hist_d = {hist_q[PAT_W-2:0], bit_in};
        fill_d = (fill_q == 3'(PAT_W)) ? fill_q : fill_q + 3'd1;
        // Compare against the history as it will be after this bit lands.
        match  = bit_en && (fill_d == 3'(PAT_W)) && (hist_d == pattern);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (bit_en) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-serialising front end for seq_match_core with saturating match counter
// and sticky threshold interrupt.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              irq_clr,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              irq,
    output logic              busy
);

    localparam int unsigned        BCNT_W    = $clog2(DATA_W);
    localparam logic [BCNT_W-1:0]  BCNT_LAST = BCNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    state_e             state_q;
    logic [DATA_W-1:0]  shreg_q;
    logic [BCNT_W-1:0]  bitcnt_q;
    logic [PAT_W-1:0]   pat_q;
    logic               match_pulse_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_q, irq_d;
    logic               bit_en;
    logic               match;

    assign bit_en = (state_q == SHIFT);

    seq_match_core u_core (
        .clk     (clk),
        .reset   (reset),
        .bit_en  (bit_en),
        .bit_in  (shreg_q[DATA_W-1]),
        .pattern (pat_q),
        .match   (match)
    );

    // A clear wins over the old count but still registers a coincident match.
    always_comb begin
        count_d = count_q;
        irq_d   = irq_q;
        if (irq_clr) begin
            count_d = match ? CNT_W'(1) : '0;
            irq_d   = match && (cfg_thresh == CNT_W'(1));
        end else if (match && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
            if ((cfg_thresh != '0) && (count_d == cfg_thresh)) begin
                irq_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bitcnt_q      <= '0;
            pat_q         <= '0;
            match_pulse_q <= 1'b0;
            count_q       <= '0;
            irq_q         <= 1'b0;
        end else begin
            match_pulse_q <= match;
            count_q       <= count_d;
            irq_q         <= irq_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shreg_q  <= in_data;
                        pat_q    <= cfg_pattern;
                        bitcnt_q <= BCNT_LAST;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
                    if (bitcnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        bitcnt_q <= bitcnt_q - BCNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q == SHIFT);
    assign match_pulse = match_pulse_q;
    assign match_count = count_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: default instance plus a CNT_W=2 instance for saturation.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic [3:0] cfg_pattern = 4'b1011;
    logic [7:0] cfg_thresh = '0;
    logic [1:0] cfg_thresh2 = '0;
    logic       irq_clr = 1'b0;

    logic       in_ready, match_pulse, irq, busy;
    logic [7:0] match_count;
    logic       in_ready2, match_pulse2, irq2, busy2;
    logic [1:0] match_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .cfg_pattern(cfg_pattern), .cfg_thresh(cfg_thresh),
        .irq_clr(irq_clr), .match_pulse(match_pulse), .match_count(match_count),
        .irq(irq), .busy(busy)
    );

    seq_detect_ctrl #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready2), .cfg_pattern(cfg_pattern), .cfg_thresh(cfg_thresh2),
        .irq_clr(irq_clr), .match_pulse(match_pulse2), .match_count(match_count2),
        .irq(irq2), .busy(busy2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Leaves the bench 1 time unit after the acceptance edge.
    task automatic send_word(input logic [7:0] w);
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_data  = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // pv[7-k] holds the pulse produced by bit k of the word just accepted.
    task automatic collect(output logic [7:0] pv);
        pv = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            pv[7-i] = match_pulse;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({in_ready, busy, match_pulse, irq} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: {rdy,busy,pulse,irq}=%b required 1000", {in_ready, busy, match_pulse, irq});
        end
        checks++;
        if (match_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d required 0", match_count);
        end
        checks++;
        if (in_ready2 !== 1'b1 || match_count2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_dut2: rdy=%b cnt=%0d required 1/0", in_ready2, match_count2);
        end
    endtask

    task automatic test_single();
        logic [7:0] pv;
        do_reset();
        cfg_pattern = 4'b1011;
        cfg_thresh  = 8'd0;
        send_word(8'hB0);
        cfg_pattern = 4'b0000;
        collect(pv);
        cfg_pattern = 4'b1011;
        checks++;
        if (pv !== 8'h10) begin
            errors++;
            $display("FAIL single_pulses: got %h required 10", pv);
        end
        checks++;
        if (match_count !== 8'd1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL single_count: cnt=%0d irq=%b required 1/0", match_count, irq);
        end
    endtask

    task automatic test_double();
        logic [7:0] pv;
        do_reset();
        send_word(8'hB6);
        collect(pv);
        checks++;
        if (pv !== 8'h12) begin
            errors++;
            $display("FAIL double_pulses: got %h required 12", pv);
        end
        checks++;
        if (match_count !== 8'd2) begin
            errors++;
            $display("FAIL double_count: got %0d required 2", match_count);
        end
    endtask

    task automatic test_boundary();
        logic [7:0] pv1, pv2;
        do_reset();
        send_word(8'h01);
        collect(pv1);
        send_word(8'h60);
        collect(pv2);
        checks++;
        if (pv1 !== 8'h00 || pv2 !== 8'h20) begin
            errors++;
            $display("FAIL boundary_pulses: got %h/%h required 00/20", pv1, pv2);
        end
        checks++;
        if (match_count !== 8'd1) begin
            errors++;
            $display("FAIL boundary_count: got %0d required 1", match_count);
        end
    endtask

    task automatic test_fill_and_overlap();
        logic [7:0] pv;
        do_reset();
        cfg_pattern = 4'b0000;
        send_word(8'h0F);
        collect(pv);
        checks++;
        if (pv !== 8'h10) begin
            errors++;
            $display("FAIL fill_gate: got %h required 10", pv);
        end
        do_reset();
        cfg_pattern = 4'b1111;
        send_word(8'hFF);
        collect(pv);
        checks++;
        if (pv !== 8'h1F || match_count !== 8'd5) begin
            errors++;
            $display("FAIL overlap: pulses=%h cnt=%0d required 1f/5", pv, match_count);
        end
        cfg_pattern = 4'b1011;
    endtask

    task automatic test_irq();
        do_reset();
        cfg_thresh = 8'd2;
        send_word(8'hB6);
        repeat (4) step();
        checks++;
        if (match_pulse !== 1'b1 || irq !== 1'b0 || match_count !== 8'd1) begin
            errors++;
            $display("FAIL irq_first: pulse=%b irq=%b cnt=%0d required 1/0/1", match_pulse, irq, match_count);
        end
        repeat (3) step();
        checks++;
        if (match_pulse !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise: pulse=%b irq=%b required 1/1", match_pulse, irq);
        end
        step();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_sticky: got %b required 1", irq);
        end
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        checks++;
        if (irq !== 1'b0 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL irq_clear: irq=%b cnt=%0d required 0/0", irq, match_count);
        end
    endtask

    task automatic test_clr_coincident();
        do_reset();
        cfg_thresh = 8'd1;
        send_word(8'hB6);
        repeat (4) step();
        checks++;
        if (irq !== 1'b1 || match_count !== 8'd1) begin
            errors++;
            $display("FAIL thresh1_irq: irq=%b cnt=%0d required 1/1", irq, match_count);
        end
        repeat (2) step();
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        checks++;
        if (match_count !== 8'd1 || irq !== 1'b1 || match_pulse !== 1'b1) begin
            errors++;
            $display("FAIL clr_coincident: cnt=%0d irq=%b pulse=%b required 1/1/1", match_count, irq, match_pulse);
        end
        step();
        cfg_thresh = 8'd0;
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        do_reset();
        cfg_thresh  = 8'd0;
        cfg_thresh2 = 2'd0;
        in_data     = 8'hB6;
        in_valid    = 1'b1;
        for (int c = 0; c < 28; c++) begin
            if (in_ready2 === 1'b1) acc++;
            step();
        end
        in_valid = 1'b0;
        repeat (9) step();
        checks++;
        if (acc != 4) begin
            errors++;
            $display("FAIL held_valid_accepts: got %0d required 4", acc);
        end
        checks++;
        if (match_count2 !== 2'd3) begin
            errors++;
            $display("FAIL saturate: got %0d required 3", match_count2);
        end
        checks++;
        if (match_count !== 8'd8 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wide_count: cnt=%0d rdy=%b required 8/1", match_count, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pv;
        do_reset();
        cfg_thresh = 8'd1;
        send_word(8'hB6);
        collect(pv);
        checks++;
        if (match_count !== 8'd2 || irq !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: cnt=%0d irq=%b required 2/1", match_count, irq);
        end
        send_word(8'hB6);
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({in_ready, busy, match_pulse, irq} !== 4'b1000 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid: {rdy,busy,pulse,irq}=%b cnt=%0d required 1000/0", {in_ready, busy, match_pulse, irq}, match_count);
        end
        collect(pv);
        checks++;
        if (pv !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %h required 00", pv);
        end
        cfg_pattern = 4'b0000;
        send_word(8'h0F);
        collect(pv);
        checks++;
        if (pv !== 8'h10) begin
            errors++;
            $display("FAIL reset_mid_history: got %h required 10", pv);
        end
        cfg_pattern = 4'b1011;
        cfg_thresh  = 8'd0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_double();
        test_boundary();
        test_fill_and_overlap();
        test_irq();
        test_clr_coincident();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
